// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// used by the requester and by completer blocks.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef logic [1:0] apb_state_t;

   localparam apb_state_t ST_IDLE   = 2'b00;
   localparam apb_state_t ST_SETUP  = 2'b01;
   localparam apb_state_t ST_ACCESS = 2'b10;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles; flags expiry on the wait cycle that brings the
// count to LIMIT. Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt;

   // This wait cycle is the LIMIT-th one, so the count reaches LIMIT now.
   assign expired = inc && (cnt == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single host commands into IDLE/SETUP/ACCESS transfers.
// Optional ACCESS wait timeout is enabled with macro APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   apb_state_t state;
   logic       accept;
   logic       timeout;

   assign cmd_ready = (state == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   apb_timeout_cnt #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .clear  (accept),
      .inc    ((state == ST_ACCESS) && !PREADY),
      .expired(timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= ST_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state  <= ST_SETUP;
                  PSEL   <= 1'b1;
                  PADDR  <= cmd_addr;
                  PWRITE <= cmd_write;
                  PWDATA <= cmd_write ? cmd_wdata : '0;
               end
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               PENABLE <= 1'b1;
            end
            ST_ACCESS: begin
               // PREADY takes priority over a timeout expiring in the same cycle.
               if (PREADY) begin
                  state     <= ST_IDLE;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= PSLVERR;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
               end else if (timeout) begin
                  state     <= ST_IDLE;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; timeout scenarios compile in when
// APB_MASTER_TIMEOUT_EN is defined, otherwise indefinite-wait is exercised.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 PCLK = ~PCLK;

   apb_master #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWDATA   (PWDATA),
      .PREADY   (PREADY),
      .PRDATA   (PRDATA),
      .PSLVERR  (PSLVERR)
   );

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   initial begin
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PREADY    = 1'b0;
      PRDATA    = '0;
      PSLVERR   = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_psel",    PSEL,      0);
      chk("rst_penable", PENABLE,   0);
      chk("rst_pwrite",  PWRITE,    0);
      chk("rst_paddr",   PADDR,     0);
      chk("rst_pwdata",  PWDATA,    0);
      chk("rst_rvalid",  rsp_valid, 0);
      chk("rst_rdata",   rsp_rdata, 0);
      chk("rst_rerr",    rsp_err,   0);
      PRESETn = 1'b1;
      tick();
      chk("rel_ready", cmd_ready, 1);

      // minimum-latency write, PREADY tied high
      PREADY = 1'b1;
      issue(1'b1, 32'h1, 32'h80);
      tick();
      cmd_valid = 1'b0;
      chk("w_setup_psel",    PSEL,      1);
      chk("w_setup_penable", PENABLE,   0);
      chk("w_setup_paddr",   PADDR,     32'h1);
      chk("w_setup_pwrite",  PWRITE,    1);
      chk("w_setup_pwdata",  PWDATA,    32'h80);
      chk("w_setup_ready",   cmd_ready, 0);
      tick();
      chk("w_acc_psel",    PSEL,      1);
      chk("w_acc_penable", PENABLE,   1);
      chk("w_acc_pwdata",  PWDATA,    32'h80);
      chk("w_acc_rvalid",  rsp_valid, 0);
      tick();
      chk("w_done_rvalid", rsp_valid, 1);
      chk("w_done_err",    rsp_err,   0);
      chk("w_done_rdata",  rsp_rdata, 0);
      chk("w_done_psel",   PSEL,      0);
      chk("w_done_pen",    PENABLE,   0);
      chk("w_done_ready",  cmd_ready, 1);
      tick();
      chk("w_idle_rvalid", rsp_valid, 0);
      chk("w_idle_paddr",  PADDR,     32'h1);
      chk("w_idle_pwdata", PWDATA,    32'h80);

      // read with 3 wait cycles; responses during SETUP must be ignored
      issue(1'b0, 32'h2, 32'hFFFF);
      tick();
      cmd_valid = 1'b0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b1;
      PRDATA    = 32'hDEAD;
      chk("r_setup_pwdata", PWDATA, 0);
      chk("r_setup_pen",    PENABLE, 0);
      tick();
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("r_wait_psel",   PSEL,      1);
         chk("r_wait_pen",    PENABLE,   1);
         chk("r_wait_paddr",  PADDR,     32'h2);
         chk("r_wait_pwrite", PWRITE,    0);
         chk("r_wait_rvalid", rsp_valid, 0);
         tick();
      end
      chk("r_acc4_psel", PSEL, 1);
      chk("r_acc4_pen",  PENABLE, 1);
      PREADY = 1'b1;
      PRDATA = 32'h1234;
      tick();
      chk("r_done_rvalid", rsp_valid, 1);
      chk("r_done_rdata",  rsp_rdata, 32'h1234);
      chk("r_done_err",    rsp_err,   0);
      PRDATA = 32'h5555;
      tick();
      chk("r_after_rvalid", rsp_valid, 0);
      chk("r_hold_rdata",   rsp_rdata, 32'h1234);

      // write with slave error, back-to-back read accepted on the response cycle
      issue(1'b1, 32'h3, 32'h55);
      tick();
      cmd_valid = 1'b0;
      PSLVERR   = 1'b1;
      tick();
      tick();
      chk("e_done_rvalid", rsp_valid, 1);
      chk("e_done_err",    rsp_err,   1);
      chk("e_done_rdata",  rsp_rdata, 0);
      chk("e_done_ready",  cmd_ready, 1);
      issue(1'b0, 32'h4, 32'h99);
      PSLVERR = 1'b0;
      tick();
      cmd_valid = 1'b0;
      chk("b2b_psel",   PSEL,      1);
      chk("b2b_paddr",  PADDR,     32'h4);
      chk("b2b_pwdata", PWDATA,    0);
      chk("b2b_rvalid", rsp_valid, 0);
      chk("b2b_errhold", rsp_err,  1);
      PREADY = 1'b1;
      PRDATA = 32'hBEEF;
      tick();
      tick();
      chk("b2b_done_rdata", rsp_rdata, 32'hBEEF);
      chk("b2b_done_err",   rsp_err,   0);
      tick();

`ifdef APB_MASTER_TIMEOUT_EN
      // timeout abort after 4 wait cycles
      PREADY = 1'b0;
      issue(1'b1, 32'h5, 32'h77);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t_wait_psel",   PSEL,      1);
         chk("t_wait_rvalid", rsp_valid, 0);
         tick();
      end
      chk("t_abort_rvalid", rsp_valid, 1);
      chk("t_abort_err",    rsp_err,   1);
      chk("t_abort_rdata",  rsp_rdata, 0);
      chk("t_abort_psel",   PSEL,      0);
      tick();

      // PREADY on the 4th wait cycle wins over timeout
      issue(1'b0, 32'h6, 32'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("t_edge_psel", PSEL, 1);
      PREADY  = 1'b1;
      PRDATA  = 32'hABC;
      PSLVERR = 1'b0;
      tick();
      chk("t_edge_rvalid", rsp_valid, 1);
      chk("t_edge_err",    rsp_err,   0);
      chk("t_edge_rdata",  rsp_rdata, 32'hABC);
      tick();
`else
      // without timeout, ACCESS waits indefinitely
      PREADY = 1'b0;
      issue(1'b1, 32'h5, 32'h77);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("nt_wait_rvalid", rsp_valid, 0);
         tick();
      end
      chk("nt_wait_psel", PSEL, 1);
      chk("nt_wait_pen",  PENABLE, 1);
      PREADY = 1'b1;
      tick();
      chk("nt_done_rvalid", rsp_valid, 1);
      chk("nt_done_err",    rsp_err,   0);
      tick();
`endif

      // reset during ACCESS of a read
      PREADY = 1'b0;
      PRDATA = 32'h7777;
      issue(1'b0, 32'h8, 32'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("rs_acc_pen", PENABLE, 1);
      PRESETn = 1'b0;
      tick();
      chk("rs_psel",   PSEL,      0);
      chk("rs_pen",    PENABLE,   0);
      chk("rs_paddr",  PADDR,     0);
      chk("rs_rvalid", rsp_valid, 0);
      chk("rs_rdata",  rsp_rdata, 0);
      chk("rs_rerr",   rsp_err,   0);
      PRESETn = 1'b1;
      PREADY  = 1'b1;
      tick();
      chk("rs_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         chk("rs_no_rvalid", rsp_valid, 0);
         chk("rs_idle_psel", PSEL, 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning PWDATA/PRDATA/cmd/rsp data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max ACCESS cycles with PREADY low (used only under APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have port PCLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port PRESETn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  host request valid.
REQ-007 SHALL have port cmd_ready  out  1  master can accept a command.
REQ-008 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have ports cmd_addr  in  ADDR_W  and cmd_wdata  in  DATA_W  (transfer address, write data).
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports rsp_rdata  out  DATA_W  and rsp_err  out  1  (read data, slave/timeout error).
REQ-012 SHALL have ports PADDR out ADDR_W, PWRITE out 1, PSEL out 1, PENABLE out 1, PWDATA out DATA_W (APB requester outputs).
REQ-013 SHALL have ports PREADY in 1, PRDATA in DATA_W, PSLVERR in 1 (APB completer responses).

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all APB outputs registered.
REQ-015 cmd_ready SHALL be 1 exactly when state = IDLE.
REQ-016 On cmd_valid && cmd_ready at edge N: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA; cycle N+1 = SETUP (PSEL=1, PENABLE=0).
REQ-017 PWDATA SHALL be cmd_wdata for writes, 0 for reads.
REQ-018 SETUP SHALL always last exactly one cycle, then ACCESS (PSEL=1, PENABLE=1).
REQ-019 In ACCESS with PREADY=0: remain in ACCESS; PADDR, PWRITE, PWDATA, PSEL, PENABLE held stable.
REQ-020 In ACCESS with PREADY=1: next cycle IDLE, PSEL=0, PENABLE=0, rsp_valid=1 for one cycle, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes.
REQ-021 rsp_rdata/rsp_err SHALL hold last values until next completion; rsp_valid=0 otherwise.
REQ-022 PREADY, PRDATA, PSLVERR SHALL be ignored outside ACCESS.
REQ-023 Minimum transfer: accept edge N, completion visible cycle N+3 (rsp_valid=1, cmd_ready=1); new command acceptable that same cycle.
REQ-024 PADDR/PWRITE/PWDATA SHALL retain last transfer values in IDLE.

Reset
REQ-025 PRESETn=0 at any edge, including mid-transfer: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0; cmd_ready=1 from first cycle after reset release.
REQ-026 An in-flight transfer aborted by reset SHALL produce no rsp_valid.

Configuration
REQ-027 Macro APB_MASTER_TIMEOUT_EN defined: counter increments each ACCESS cycle with PREADY=0; counter reaching TIMEOUT_CYCLES with PREADY still 0 SHALL end transfer: next cycle IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; counter cleared on entry to SETUP.
REQ-028 PREADY=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally (PREADY wins).
REQ-029 Macro undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Structure
REQ-030 Shared package apb_pkg SHALL hold FSM state type (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and default ADDR_W/DATA_W constants, shared with APB completer blocks.
REQ-031 Timeout counter SHALL be sub-module apb_timeout_cnt, instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-032 Write addr 0x1, data 0x80, PREADY tied 1 -> SETUP one cycle then ACCESS one cycle, PWDATA=0x80 both, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-033 Read addr 0x2, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234 -> signals stable 4 ACCESS cycles, rsp_rdata=0x1234, rsp_valid single pulse.
REQ-034 Write with PSLVERR=1 at PREADY=1 -> rsp_err=1; next command accepted same cycle as rsp_valid.
REQ-035 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0 next cycle; repeat with PREADY=1 on 4th cycle -> normal completion, rsp_err=PSLVERR.
REQ-036 PRESETn=0 during ACCESS of a read -> next cycle PSEL=PENABLE=0, cmd_ready=1 after release, no rsp_valid ever seen for that read.
